clmul_seq_ctrl: RTL
===================

// Module: clmul_seq_ctrl
// PURPOSE
//  Sequencer that computes a W-bit x W-bit carry-less (GF(2) polynomial) product.
//  It time-shares one combinational 8x8 carry-less multiplier core over NW*NW cycles.
//  It feeds byte pairs to the core, shifts each 15-bit partial product and XOR-accumulates it.
//  Sits between operand producers (valid/ready) and GF(2^m) reduction / MAC stages.
// PARAMETERS
//  NW    4   number of 8-bit operand slices; W = 8*NW; supported 1..8
//  PIPE  0   1 = register core output before accumulate (adds 1 cycle); 0 = direct
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       block can accept operands
//  in_a       in   W       multiplicand polynomial, bit k = coeff x^k
//  in_b       in   W       multiplier polynomial
//  out_valid  out  1       result valid, held until out_ready
//  out_ready  in   1       consumer accepts result
//  out_y      out  2W-1    carry-less product a*b over GF(2)
//  busy       out  1       high in RUN/DRAIN/DONE
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_y=0, counters=0, accumulator=0.
//  - FSM states: IDLE -> RUN -> (DRAIN if PIPE) -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&in_ready: latch in_a/in_b, clear accumulator, i=j=0, go to RUN.
//  - RUN: one step per cycle.
//    - Core inputs are a_reg[8i+:8] and b_reg[8j+:8].
//    - acc[8(i+j)+:15] ^= core_y.
//    - j is the inner index: j increments and wraps at NW-1, then i increments.
//    - After step (NW-1,NW-1): go to DONE (PIPE=0) or DRAIN (PIPE=1).
//  - DRAIN (PIPE=1 only):
//    - The registered last product is XORed in.
//    - Then go to DONE.
//  - DONE:
//    - out_valid=1, out_y=acc.
//    - On out_ready: go to IDLE.
//  - Latency: out_valid rises exactly NW*NW+PIPE+1 cycles after the accept cycle.
//    - NW=4, PIPE=0: 17 cycles.
//  - Throughput: one product per NW*NW+PIPE+2 cycles with out_ready tied high.
//  - Handshakes:
//    - in_ready is low outside IDLE; in_valid there is ignored, operands are not sampled.
//    - out_y and out_valid stay stable while out_valid=1 and out_ready=0.
//    - The block never drops or duplicates a result.
//    - No accept in the same cycle as the result handshake; IDLE is mandatory between operations.
//  - Width rules:
//    - Accumulator is 2W-1 bits.
//    - Highest write is at offset 8*(2NW-2) with 15 bits, ending at bit 2W-2: no overflow, no truncation.
//    - All combination is XOR; no carries anywhere.
//  - Operand registers are captured only on accept; in_a/in_b changes during RUN have no effect.
//  - rst mid-operation: abort next edge, all outputs return to reset values, partial result discarded.
//  - rst has priority over every handshake in the same cycle.
// STRUCTURE
//  - Shared package clmul_pkg:
//    - SLICE_W=8, PP_W=15.
//    - State enum {S_IDLE,S_RUN,S_DRAIN,S_DONE}.
//    - Function clmul_ref(a,b) for the bench.
//  - One sub-module: clmul8_core.
//    - Combinational 8x8 -> 15-bit GF(2) product (existing gate-level core).
//    - Instantiated once.
//  - Index counters i,j are $clog2(NW) bits (min 1).
// TESTING
//  - NW=4,PIPE=0: a=0x00000003, b=0x00000003 -> out_y=0x5 (not 9), out_valid 17 cycles after accept.
//  - a=0x000000FF, b=0x000000FF -> out_y=0x5555; a=0xFFFFFFFF, b=0x1 -> out_y=0xFFFFFFFF.
//  - a=b=0x80000000 -> out_y=0x4000_0000_0000_0000 (only bit 62 set); a=0 or b=0 -> 0.
//  - Hold out_ready=0 for 10 cycles in DONE -> out_y stable, in_ready=0, in_valid pulses ignored.
//    - Then out_ready=1 -> IDLE next cycle.
//  - Assert rst at RUN step 5 -> next cycle IDLE, out_valid=0, in_ready=1.
//    - Next op a=5, b=7 -> out_y=0x1B.
//  - PIPE=1 and NW=1,2,8: 1000 random pairs vs clmul_ref with random out_ready.
//    - Latency must be NW*NW+2 cycles.

Source files
------------

// File: rtl/clmul_pkg.sv
// Shared types and constants for the sequential carry-less multiplier.
// Also holds the plain reference product used when checking the block.
package clmul_pkg;

  localparam int unsigned SLICE_W = 8;
  localparam int unsigned PP_W    = 2 * SLICE_W - 1;
  localparam int unsigned MAX_NW  = 8;
  localparam int unsigned MAX_W   = SLICE_W * MAX_NW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [2*MAX_W-2:0] clmul_ref(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b);
    logic [2*MAX_W-2:0] r;
    r = '0;
    for (int unsigned k = 0; k < MAX_W; k++) begin
      if (b[k]) r = r ^ ((2*MAX_W-1)'(a) << k);
    end
    return r;
  endfunction

endpackage

// File: rtl/clmul8_core.sv
// Combinational 8x8 -> 15-bit GF(2) polynomial product.
// Each output bit is the XOR of all partial-product terms of equal degree.
module clmul8_core
  import clmul_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  output logic [PP_W-1:0]    y_o
);

  always_comb begin
    y_o = '0;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      for (int unsigned j = 0; j < SLICE_W; j++) begin
        y_o[i+j] = y_o[i+j] ^ (a_i[i] & b_i[j]);
      end
    end
  end

endmodule

// File: rtl/clmul_seq_ctrl.sv
// Sequential W x W carry-less multiplier: walks all NW*NW byte pairs through one
// 8x8 core and XOR-accumulates the shifted partial products into a 2W-1 bit result.
module clmul_seq_ctrl
  import clmul_pkg::*;
#(
  parameter int unsigned NW   = 4,
  parameter bit          PIPE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*NW-1:0]      in_a,
  input  logic [SLICE_W*NW-1:0]      in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*SLICE_W*NW-2:0]    out_y,
  output logic                       busy
);

  localparam int unsigned W     = SLICE_W * NW;
  localparam int unsigned AW    = 2 * W - 1;
  localparam int unsigned IW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned SW    = IW + 1;
  localparam int unsigned LOG_S = $clog2(SLICE_W);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     i_q, i_d;
  logic [IW-1:0]     j_q, j_d;

  logic [SLICE_W-1:0] core_a, core_b;
  logic [PP_W-1:0]    core_y;
  logic [SW-1:0]      sum;
  logic               last_step;

  logic [PP_W-1:0]    add_pp;
  logic [SW-1:0]      add_off;
  logic               add_en;
  logic [AW-1:0]      pp_shift;

  assign last_step = (i_q == IW'(NW - 1)) && (j_q == IW'(NW - 1));
  assign sum       = SW'(i_q) + SW'(j_q);

  always_comb begin
    core_a = '0;
    core_b = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      if (i_q == IW'(k)) core_a = a_q[SLICE_W*k +: SLICE_W];
      if (j_q == IW'(k)) core_b = b_q[SLICE_W*k +: SLICE_W];
    end
  end

  clmul8_core u_core (
    .a_i (core_a),
    .b_i (core_b),
    .y_o (core_y)
  );

  // With PIPE the product and its slice offset travel together one cycle late,
  // so the final step is folded in during DRAIN.
  if (PIPE) begin : g_pipe
    logic [PP_W-1:0] pp_q;
    logic [SW-1:0]   off_q;
    logic            pv_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        pp_q  <= '0;
        off_q <= '0;
        pv_q  <= 1'b0;
      end else begin
        pp_q  <= core_y;
        off_q <= sum;
        pv_q  <= (state_q == S_RUN);
      end
    end

    assign add_pp  = pp_q;
    assign add_off = off_q;
    assign add_en  = pv_q;
  end else begin : g_direct
    assign add_pp  = core_y;
    assign add_off = sum;
    assign add_en  = (state_q == S_RUN);
  end

  assign pp_shift = AW'(add_pp) << {add_off, {LOG_S{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_step) state_d = PIPE ? S_DRAIN : S_DONE;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    out_y     = out_valid ? acc_q : '0;
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = add_en ? (acc_q ^ pp_shift) : acc_q;
    i_d   = i_q;
    j_d   = j_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d   = in_a;
      b_d   = in_b;
      acc_d = '0;
      i_d   = '0;
      j_d   = '0;
    end else if (state_q == S_RUN) begin
      if (last_step) begin
        i_d = '0;
        j_d = '0;
      end else if (j_q == IW'(NW - 1)) begin
        i_d = i_q + 1'b1;
        j_d = '0;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      i_q   <= i_d;
      j_q   <= j_d;
    end
  end

endmodule
